// File: rtl/feedback_loop_ctrl_pkg.sv
// Shared types for the feedback-loop sequencer: packed signed pair, FSM states.
package feedback_loop_ctrl_types;
  localparam int PAIR_W = 16;

  typedef struct packed {
    logic signed [7:0] sel0;
    logic signed [7:0] sel1;
  } pair_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  function automatic pair_t pair_from_lv(input logic [PAIR_W-1:0] v);
    return pair_t'(v);
  endfunction

  function automatic logic [PAIR_W-1:0] pair_to_lv(input pair_t p);
    return p;
  endfunction
endpackage

// File: rtl/feedback_loop_ctrl.sv
// Drives an external combinational step unit once per cycle until the
// iteration budget runs out or the pair stops changing, then returns the result.
module feedback_loop_ctrl
  import feedback_loop_ctrl_types::*;
#(
  parameter int ITER_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [PAIR_W-1:0] start_state,
  input  logic [ITER_W-1:0] start_iters,
  output logic [PAIR_W-1:0] dp_state,
  input  logic [PAIR_W-1:0] dp_next,
  output logic              busy,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [PAIR_W-1:0] res_state,
  output logic [ITER_W-1:0] res_count,
  output logic              res_fixed
);
  fsm_t              fsm;
  pair_t             state;
  pair_t             next;
  logic [ITER_W-1:0] remaining;
  logic [ITER_W-1:0] count;
  logic              fixed;
  logic              at_fixed;

  assign next      = pair_from_lv(dp_next);
  assign at_fixed  = (next == state);
  assign dp_state  = pair_to_lv(state);
  assign res_state = pair_to_lv(state);
  assign res_count = count;
  assign res_fixed = fixed;

  // Handshake/status flags are registered alongside the state transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm         <= IDLE;
      state       <= '0;
      remaining   <= '0;
      count       <= '0;
      fixed       <= 1'b0;
      start_ready <= 1'b1;
      busy        <= 1'b0;
      res_valid   <= 1'b0;
    end else begin
      case (fsm)
        IDLE: if (start_valid && start_ready) begin
          state       <= pair_from_lv(start_state);
          remaining   <= start_iters;
          count       <= '0;
          fixed       <= 1'b0;
          start_ready <= 1'b0;
          if (start_iters != '0) begin
            fsm  <= RUN;
            busy <= 1'b1;
          end else begin
            fsm       <= DONE;
            res_valid <= 1'b1;
          end
        end
        RUN: begin
          state     <= next;
          count     <= count + ITER_W'(1);
          remaining <= remaining - ITER_W'(1);
          // A step that lands on a fixed point is still counted.
          if (at_fixed || remaining == ITER_W'(1)) begin
            fixed     <= at_fixed;
            fsm       <= DONE;
            busy      <= 1'b0;
            res_valid <= 1'b1;
          end
        end
        DONE: if (res_ready) begin
          fsm         <= IDLE;
          res_valid   <= 1'b0;
          start_ready <= 1'b1;
        end
        default: begin
          fsm         <= IDLE;
          start_ready <= 1'b1;
          busy        <= 1'b0;
          res_valid   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_feedback_loop_ctrl.sv
// Directed + random jobs against a loop-level reference of the sequencer.
module tb_feedback_loop_ctrl;
  localparam int ITER_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start_valid = 1'b0;
  logic              start_ready;
  logic [15:0]       start_state = '0;
  logic [ITER_W-1:0] start_iters = '0;
  logic [15:0]       dp_state;
  logic [15:0]       dp_next;
  logic              busy;
  logic              res_valid;
  logic              res_ready = 1'b1;
  logic [15:0]       res_state;
  logic [ITER_W-1:0] res_count;
  logic              res_fixed;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  feedback_loop_ctrl #(.ITER_W(ITER_W)) dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready),
    .start_state(start_state), .start_iters(start_iters),
    .dp_state(dp_state), .dp_next(dp_next),
    .busy(busy),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_state(res_state), .res_count(res_count), .res_fixed(res_fixed)
  );

  // Step unit: {sel0+sel1 (wrapping), sel0}
  function automatic logic [15:0] step(input logic [15:0] s);
    logic [7:0] a, b;
    a = s[15:8];
    b = s[7:0];
    return {8'(a + b), a};
  endfunction

  assign dp_next = step(dp_state);

  // Reference: iterate the step rule up to n times, stopping on a repeat.
  task automatic ref_run(input logic [15:0] s, input int n,
                         output logic [15:0] st, output int cnt, output bit fx);
    logic [15:0] nx;
    st = s; cnt = 0; fx = 0;
    for (int i = 0; i < n; i++) begin
      nx = step(st);
      cnt++;
      if (nx == st) begin fx = 1; break; end
      st = nx;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT in IDLE. hold = cycles of res_ready low;
  // keep_valid keeps start_valid asserted during the hold window.
  task automatic run_job(input logic [15:0] s, input int n, input int hold,
                         input bit keep_valid);
    logic [15:0] e_st;
    int          e_cnt, lat, bcnt;
    bit          e_fx;
    ref_run(s, n, e_st, e_cnt, e_fx);
    chk("accept_ready", start_ready, 1);
    start_valid = 1'b1;
    start_state = s;
    start_iters = ITER_W'(n);
    res_ready   = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    start_state = 16'($urandom);
    start_iters = ITER_W'($urandom);
    lat = 1; bcnt = 0;
    while (!res_valid && lat < 600) begin
      if (busy) bcnt++;
      chk("run_dp_state_tracks", dp_state, dp_state === res_state ? dp_state : res_state);
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, e_cnt + 1);
    chk("busy_cycles", bcnt, e_cnt);
    chk("res_state", res_state, e_st);
    chk("res_count", res_count, e_cnt);
    chk("res_fixed", res_fixed, e_fx);
    chk("done_start_ready", start_ready, 0);
    for (int i = 0; i < hold; i++) begin
      start_valid = keep_valid;
      @(negedge clk);
      chk("hold_valid", res_valid, 1);
      chk("hold_state", res_state, e_st);
      chk("hold_count", res_count, e_cnt);
      chk("hold_fixed", res_fixed, e_fx);
      chk("hold_start_ready", start_ready, 0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    chk("idle_res_valid", res_valid, 0);
    chk("idle_start_ready", start_ready, 1);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    bit seen;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_start_ready", start_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_state", res_state, 0);
    chk("rst_res_count", res_count, 0);
    chk("rst_res_fixed", res_fixed, 0);
    chk("rst_dp_state", dp_state, 0);

    // Directed cases, with literal expectations from hand iteration.
    run_job(16'h0100, 5, 0, 0);
    chk("basic_lit", res_state, 16'h0805);
    run_job(16'h0100, 11, 0, 0);
    chk("wrap_lit", res_state, 16'h9059);
    run_job(16'h0000, 20, 0, 0);
    chk("fixed_lit", {res_fixed, res_count}, {1'b1, 8'd1});
    run_job(16'h7F80, 0, 0, 0);
    chk("zero_lit", res_state, 16'h7F80);

    // Backpressure with start_valid high, then back-to-back accept.
    run_job(16'h0302, 3, 4, 1);
    run_job(16'h0100, 4, 0, 0);
    chk("b2b_lit", res_state, 16'h0503);

    // Reset on the 3rd RUN cycle of a 10-step job.
    start_valid = 1'b1; start_state = 16'h0100; start_iters = 8'd10;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_ready", start_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", res_valid, 0);
    chk("mid_rst_state", res_state, 0);
    chk("mid_rst_count", res_count, 0);
    chk("mid_rst_fixed", res_fixed, 0);
    chk("mid_rst_dp", dp_state, 0);
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (res_valid) seen = 1;
    end
    chk("aborted_no_result", seen, 0);

    // Random jobs.
    for (int j = 0; j < 30; j++)
      run_job(16'($urandom), int'($urandom_range(0, 40)),
              int'($urandom_range(0, 3)), 1'($urandom));
    run_job(16'($urandom), 255, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
